// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller: FSM states, time limits
// and the encodings driven on the setting output.
package alarm_pkg;

  typedef enum logic [2:0] {IDLE, SET_H, SET_M, RING, SNOOZE} alm_state_t;

  localparam logic [4:0] HRS_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

  localparam logic [1:0] SET_NONE = 2'b00;
  localparam logic [1:0] SET_HRS  = 2'b01;
  localparam logic [1:0] SET_MIN  = 2'b10;

endpackage

// File: rtl/hm_add.sv
// Combinational hh:mm plus a minute offset; minutes wrap mod 60 with carry
// into hours, hours wrap mod 24. Offsets up to 63 can carry two hours.
module hm_add
  import alarm_pkg::*;
(
  input  logic [4:0] i_hrs,
  input  logic [5:0] i_min,
  input  logic [5:0] i_off,
  output logic [4:0] o_hrs,
  output logic [5:0] o_min
);

  logic [6:0] w_msum;
  logic [6:0] w_mrem;
  logic [1:0] w_carry;
  logic [5:0] w_hsum;
  logic [5:0] w_hwrap;

  assign w_msum = {1'b0, i_min} + {1'b0, i_off};

  always_comb begin
    w_carry = 2'd0;
    w_mrem  = w_msum;
    if (w_msum > 7'd119) begin
      w_carry = 2'd2;
      w_mrem  = w_msum - 7'd120;
    end else if (w_msum > {1'b0, MIN_MAX}) begin
      w_carry = 2'd1;
      w_mrem  = w_msum - 7'd60;
    end
  end

  assign w_hsum  = {1'b0, i_hrs} + {4'b0, w_carry};
  assign w_hwrap = w_hsum - 6'd24;
  assign o_min   = w_mrem[5:0];
  assign o_hrs   = (w_hsum > {1'b0, HRS_MAX}) ? w_hwrap[4:0] : w_hsum[4:0];

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: programmable alarm time, ring/snooze/timeout sequencing
// against the live time from the timekeeper. Buzzer enable is registered.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic [4:0] i_hrs,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic       i_alm_en,
  input  logic       i_set_alm,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_snooze,
  input  logic       i_stop,
  output logic [4:0] o_alm_hrs,
  output logic [5:0] o_alm_min,
  output logic       o_ringing,
  output logic [1:0] o_setting,
  output logic       o_snz_active
);

  localparam int SCW = $clog2(MAX_SNOOZE + 1);
  localparam logic [SCW-1:0] SNZ_LIMIT = SCW'(MAX_SNOOZE);
  localparam logic [7:0]     RING_LAST = 8'(RING_SEC - 1);
  localparam logic [5:0]     SNZ_OFF   = 6'(SNOOZE_MIN);

  function automatic logic [4:0] hrs_step(input logic [4:0] v, input logic up);
    if (up) return (v == HRS_MAX) ? 5'd0 : v + 5'd1;
    return (v == 5'd0) ? HRS_MAX : v - 5'd1;
  endfunction

  function automatic logic [5:0] min_step(input logic [5:0] v, input logic up);
    if (up) return (v == MIN_MAX) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? MIN_MAX : v - 6'd1;
  endfunction

  alm_state_t     r_state, w_next;
  logic [4:0]     r_alm_hrs, w_alm_hrs, r_snz_hrs, w_tgt_hrs;
  logic [5:0]     r_alm_min, w_alm_min, r_snz_min, w_tgt_min;
  logic [SCW-1:0] r_snz_cnt, w_snz_cnt;
  logic [7:0]     r_ring_cnt, w_ring_cnt;
  logic           r_ringing, r_snz_active, w_snz_load;
  logic [1:0]     r_setting, w_setting;
  logic           w_on_min, w_alm_hit, w_snz_hit, w_step;

  hm_add u_snz_tgt (
    .i_hrs (i_hrs),
    .i_min (i_min),
    .i_off (SNZ_OFF),
    .o_hrs (w_tgt_hrs),
    .o_min (w_tgt_min)
  );

  assign w_on_min  = i_tick && (i_sec == 6'd0);
  assign w_alm_hit = w_on_min && i_alm_en && (i_hrs == r_alm_hrs) && (i_min == r_alm_min);
  assign w_snz_hit = w_on_min && (i_hrs == r_snz_hrs) && (i_min == r_snz_min);
  // inc and dec together cancel out
  assign w_step    = i_inc ^ i_dec;

  always_comb begin
    w_next     = r_state;
    w_alm_hrs  = r_alm_hrs;
    w_alm_min  = r_alm_min;
    w_snz_cnt  = r_snz_cnt;
    w_ring_cnt = r_ring_cnt;
    w_snz_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_set_alm) w_next = SET_H;
        else if (w_alm_hit) begin
          w_next     = RING;
          w_ring_cnt = 8'd0;
        end
      end
      SET_H: begin
        if (i_set_alm)   w_next = SET_M;
        else if (w_step) w_alm_hrs = hrs_step(r_alm_hrs, i_inc);
      end
      SET_M: begin
        if (i_set_alm)   w_next = IDLE;
        else if (w_step) w_alm_min = min_step(r_alm_min, i_inc);
      end
      RING: begin
        if (!i_alm_en || i_stop) w_next = IDLE;
        else if (i_snooze) begin
          if (r_snz_cnt < SNZ_LIMIT) begin
            w_next     = SNOOZE;
            w_snz_load = 1'b1;
            w_snz_cnt  = r_snz_cnt + 1'b1;
          end else begin
            w_next = IDLE;
          end
        end else if (i_tick) begin
          if (r_ring_cnt == RING_LAST) w_next = IDLE;
          else                         w_ring_cnt = r_ring_cnt + 8'd1;
        end
      end
      SNOOZE: begin
        if (!i_alm_en || i_stop) w_next = IDLE;
        else if (w_snz_hit) begin
          w_next     = RING;
          w_ring_cnt = 8'd0;
        end
      end
      default: w_next = IDLE;
    endcase
    // snooze budget belongs to one alarm event; any return to IDLE ends it
    if (w_next == IDLE) w_snz_cnt = '0;
    w_setting = SET_NONE;
    if (w_next == SET_H) w_setting = SET_HRS;
    if (w_next == SET_M) w_setting = SET_MIN;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_alm_hrs    <= '0;
      r_alm_min    <= '0;
      r_snz_hrs    <= '0;
      r_snz_min    <= '0;
      r_snz_cnt    <= '0;
      r_ring_cnt   <= '0;
      r_ringing    <= 1'b0;
      r_setting    <= SET_NONE;
      r_snz_active <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_alm_hrs    <= w_alm_hrs;
      r_alm_min    <= w_alm_min;
      r_snz_cnt    <= w_snz_cnt;
      r_ring_cnt   <= w_ring_cnt;
      r_ringing    <= (w_next == RING);
      r_setting    <= w_setting;
      r_snz_active <= (w_next == SNOOZE);
      if (w_snz_load) begin
        r_snz_hrs <= w_tgt_hrs;
        r_snz_min <= w_tgt_min;
      end
    end
  end

  assign o_alm_hrs    = r_alm_hrs;
  assign o_alm_min    = r_alm_min;
  assign o_ringing    = r_ringing;
  assign o_setting    = r_setting;
  assign o_snz_active = r_snz_active;

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm controller for the alarm-clock timekeeper. It holds the programmable alarm time and compares it against the live hours/minutes/seconds from the timekeeping counter. On a match it sequences the ring, snooze and timeout behaviour. It sits beside the timekeeper, consuming its time outputs and the shared button pulses, and drives the buzzer enable.

## Interface
Parameters:
- SNOOZE_MIN, default 5: minutes added to the current time on snooze (1..59).
- RING_SEC, default 60: seconds of ringing before automatic timeout (1..255).
- MAX_SNOOZE, default 3: snoozes allowed per alarm event; the next snooze acts as stop.

Ports:
- clk  in  1  system clock, single domain.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle pulse per second, aligned with the timekeeper's seconds update.
- hrs  in  5  current hours, 0..23.
- min  in  6  current minutes, 0..59.
- sec  in  6  current seconds, 0..59.
- alm_en  in  1  level; alarm armed when high.
- set_alm  in  1  one-cycle pulse; enters or advances alarm-set mode.
- inc  in  1  one-cycle pulse; increment the selected field.
- dec  in  1  one-cycle pulse; decrement the selected field.
- snooze  in  1  one-cycle pulse; snooze request.
- stop  in  1  one-cycle pulse; stop ringing.
- alm_hrs  out  5  programmed alarm hours.
- alm_min  out  6  programmed alarm minutes.
- ringing  out  1  buzzer enable, registered.
- setting  out  2  00 none, 01 hours selected, 10 minutes selected.
- snz_active  out  1  high while a snooze is pending.

## Operation
- States: IDLE, SET_H, SET_M, RING, SNOOZE.
- IDLE:
  - set_alm goes to SET_H.
  - A match goes to RING. A match requires tick=1, alm_en=1, hrs==alm_hrs, min==alm_min and sec==0.
- SET_H:
  - inc/dec wrap alm_hrs modulo 24 (23+1 gives 0; 0-1 gives 23).
  - set_alm goes to SET_M.
- SET_M:
  - inc/dec wrap alm_min modulo 60.
  - set_alm returns to IDLE.
- In SET_H or SET_M:
  - inc and dec high in the same cycle: hold the field.
  - set_alm together with inc/dec: the state advances and the field holds.
  - A match in these states is ignored.
- RING:
  - ringing=1. ring_cnt counts ticks.
  - stop goes to IDLE and clears snz_cnt.
  - snooze with snz_cnt<MAX_SNOOZE: load snz_hrs:snz_min = (hrs:min + SNOOZE_MIN) with minutes wrapping into hours and hours modulo 24; increment snz_cnt; go to SNOOZE.
  - snooze with snz_cnt==MAX_SNOOZE behaves as stop.
  - stop and snooze in the same cycle: stop wins.
  - ring_cnt reaching RING_SEC on a tick goes to IDLE and clears snz_cnt.
  - set_alm, inc and dec are ignored.
- SNOOZE:
  - snz_active=1.
  - Goes to RING when tick=1, hrs==snz_hrs, min==snz_min and sec==0; ring_cnt clears on entry.
  - stop goes to IDLE and clears snz_cnt.
  - alm_en falling (deasserted) goes to IDLE.
  - set_alm is ignored.
- Any state except SET_H/SET_M: alm_en=0 forces IDLE within one cycle, unless the state is SET_H or SET_M.
- Reset values:
  - state = IDLE.
  - alm_hrs=0, alm_min=0, ringing=0, setting=00, snz_active=0.
  - snz_cnt=0, ring_cnt=0.
  - Reset mid-ring silences ringing immediately, asynchronously.

## Timing
- All outputs are registered.
- ringing rises in the cycle after the match cycle (1-cycle latency). It falls in the cycle after stop, snooze or timeout.
- inc/dec take effect on alm_hrs/alm_min in the cycle after the pulse.
- setting and snz_active follow the state register with no extra delay.
- Ring duration is RING_SEC ticks, counted from the first tick after entering RING.
- Pulses are assumed one cycle wide. A level held N cycles acts as N pulses.

## Structure
- Shared package alarm_pkg holds:
  - the state enum alm_state_t {IDLE, SET_H, SET_M, RING, SNOOZE};
  - constants HRS_MAX=23 and MIN_MAX=59;
  - the setting encodings.
- Sub-module hm_add: combinational hours:minutes plus a 6-bit minute offset, with modulo-60 carry into modulo-24 hours. It is used for the snooze target.
- Wrap inc/dec helpers stay local.
- Target size is about 200 lines of RTL.

## Test plan
- Reset, then set_alm, 7×inc, set_alm, 30×inc, set_alm -> alm_hrs=7, alm_min=30, setting=00; state IDLE.
- alm_en=1, time 07:30:00 with tick -> ringing=1 next cycle. stop -> ringing=0 next cycle, and an immediate rematch does not retrigger.
- Alarm 23:58 rings, snooze at 23:58:10 -> snz target 00:03. ringing=1 at 00:03:00 plus one cycle; snz_active=1 in between.
- Ringing, no input -> ringing=0 after exactly RING_SEC=60 ticks. Separately, 4th snooze with MAX_SNOOZE=3 -> state IDLE, no snz_active.
- SET_H at alm_hrs=0: dec -> 23; inc+dec together -> 23 held. SET_M at 59: inc -> 0.
- rst_n low mid-RING -> ringing=0 asynchronously. Then alm_en=0 during SNOOZE -> IDLE, and the snooze target passes silently.
